// File: rtl/pe_pixel_loader.sv
// pe_pixel_loader: packs a serial RGB pixel stream into NUM_PIXELS-wide buses for one
// pe instance, then sequences its summing and background-removal passes with a
// Start / wait-for-done / Ack handshake. A watchdog flags a pe that never finishes.
module pe_pixel_loader #(
  parameter int NUM_PIXELS = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [7:0]              pix_r,
  input  logic [7:0]              pix_g,
  input  logic [7:0]              pix_b,
  output logic [8*NUM_PIXELS-1:0] red_in,
  output logic [8*NUM_PIXELS-1:0] green_in,
  output logic [8*NUM_PIXELS-1:0] blue_in,
  output logic                    Start_Sum,
  output logic                    Start_BgRemoval,
  output logic                    Ack,
  input  logic                    Qsd,
  input  logic                    Qbgd,
  output logic                    frame_done,
  output logic                    timeout_err,
  output logic                    busy
);

  localparam int CW       = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int WW       = (TIMEOUT > 2) ? $clog2(TIMEOUT + 1) : 2;
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit TMO_EN   = (TIMEOUT > 0);

  localparam logic [CW-1:0] PIX_LAST  = CW'(NUM_PIXELS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TMO_LAST);
  localparam logic [WW-1:0] WAIT_MAX  = {WW{1'b1}};
  localparam logic [WW-1:0] WAIT_ZERO = {WW{1'b0}};

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    SUM_GO   = 3'd1,
    SUM_WAIT = 3'd2,
    BG_GO    = 3'd3,
    BG_WAIT  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic [CW-1:0]           pix_cnt_r;
  logic [WW-1:0]           wait_cnt_r;
  logic [8*NUM_PIXELS-1:0] red_r;
  logic [8*NUM_PIXELS-1:0] green_r;
  logic [8*NUM_PIXELS-1:0] blue_r;
  logic                    pix_ready_r;
  logic                    start_sum_r;
  logic                    start_bg_r;
  logic                    frame_done_r;
  logic                    timeout_err_r;
  logic                    busy_r;
  logic                    xfer_s;
  logic                    last_pix_s;
  logic                    early_s;
  logic                    tmo_s;
  logic                    ack_s;
  logic                    tmo_hit_s;

  // A pixel moves only when the loader advertises ready; ready is only ever high in LOAD.
  assign xfer_s     = pix_valid & pix_ready_r;
  assign last_pix_s = xfer_s & (pix_cnt_r == PIX_LAST);
  // The first cycle of a wait state ignores the done flag (it may be stale from the pe).
  assign early_s    = (wait_cnt_r == WAIT_ZERO);
  assign tmo_s      = TMO_EN & (wait_cnt_r == WAIT_LAST);

  // Next-state and Mealy Ack / timeout decode for the batch sequencer.
  always_comb begin
    next_state_s = state_r;
    ack_s        = 1'b0;
    tmo_hit_s    = 1'b0;
    case (state_r)
      LOAD: begin
        if (last_pix_s) begin
          next_state_s = SUM_GO;
        end else begin
          next_state_s = LOAD;
        end
      end
      SUM_GO: begin
        next_state_s = SUM_WAIT;
      end
      SUM_WAIT: begin
        if (!early_s && Qsd) begin
          ack_s        = 1'b1;
          next_state_s = BG_GO;
        end else if (tmo_s) begin
          tmo_hit_s    = 1'b1;
          next_state_s = LOAD;
        end else begin
          next_state_s = SUM_WAIT;
        end
      end
      BG_GO: begin
        next_state_s = BG_WAIT;
      end
      BG_WAIT: begin
        if (!early_s && Qbgd) begin
          ack_s        = 1'b1;
          next_state_s = DONE;
        end else if (tmo_s) begin
          tmo_hit_s    = 1'b1;
          next_state_s = LOAD;
        end else begin
          next_state_s = BG_WAIT;
        end
      end
      DONE: begin
        next_state_s = LOAD;
      end
      default: begin
        next_state_s = LOAD;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= LOAD;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Pixel slot counter: advances per transfer, wraps after the last slot, idle outside LOAD.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_cnt_r <= {CW{1'b0}};
    end else if (state_r != LOAD) begin
      pix_cnt_r <= {CW{1'b0}};
    end else if (xfer_s) begin
      pix_cnt_r <= (pix_cnt_r == PIX_LAST) ? {CW{1'b0}} : pix_cnt_r + 1'b1;
    end
  end

  // Packed pixel buses: written only by transfers, held across both pe passes and batches.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      red_r   <= {(8*NUM_PIXELS){1'b0}};
      green_r <= {(8*NUM_PIXELS){1'b0}};
      blue_r  <= {(8*NUM_PIXELS){1'b0}};
    end else if ((state_r == LOAD) && xfer_s) begin
      red_r[8*pix_cnt_r +: 8]   <= pix_r;
      green_r[8*pix_cnt_r +: 8] <= pix_g;
      blue_r[8*pix_cnt_r +: 8]  <= pix_b;
    end
  end

  // Wait-cycle counter: counts cycles spent in a wait state (saturating), cleared elsewhere.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt_r <= WAIT_ZERO;
    end else if ((state_r == SUM_WAIT) || (state_r == BG_WAIT)) begin
      if (wait_cnt_r != WAIT_MAX) begin
        wait_cnt_r <= wait_cnt_r + 1'b1;
      end
    end else begin
      wait_cnt_r <= WAIT_ZERO;
    end
  end

  // Registered status/pulse outputs, each decoded from the state being entered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_ready_r   <= 1'b0;
      start_sum_r   <= 1'b0;
      start_bg_r    <= 1'b0;
      frame_done_r  <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      pix_ready_r   <= (next_state_s == LOAD);
      start_sum_r   <= (next_state_s == SUM_GO);
      start_bg_r    <= (next_state_s == BG_GO);
      frame_done_r  <= (next_state_s == DONE);
      busy_r        <= (next_state_s != LOAD);
      timeout_err_r <= timeout_err_r | tmo_hit_s;
    end
  end

  assign pix_ready       = pix_ready_r;
  assign red_in          = red_r;
  assign green_in        = green_r;
  assign blue_in         = blue_r;
  assign Start_Sum       = start_sum_r;
  assign Start_BgRemoval = start_bg_r;
  assign Ack             = ack_s;
  assign frame_done      = frame_done_r;
  assign timeout_err     = timeout_err_r;
  assign busy            = busy_r;

endmodule

// File: tb/tb_pe_pixel_loader.sv
// Scoreboard bench for pe_pixel_loader: a driver streams pixels and plays the pe,
// pushing expected packed buses into queues; a monitor compares them on every
// Start_Sum and frame_done pulse.
module tb_pe_pixel_loader;

  localparam int NP  = 4;
  localparam int TMO = 16;
  localparam int W   = 8 * NP;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         pix_valid = 1'b0;
  logic [7:0]   pix_r = 8'd0, pix_g = 8'd0, pix_b = 8'd0;
  logic         Qsd = 1'b0, Qbgd = 1'b0;
  logic         pix_ready;
  logic [W-1:0] red_in, green_in, blue_in;
  logic         Start_Sum, Start_BgRemoval, Ack, frame_done, timeout_err, busy;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] g;
    logic [W-1:0] b;
  } bus_t;

  bus_t       exp_sum[$];
  bus_t       exp_done[$];
  bus_t       last_batch;
  bus_t       mon_e;
  logic [7:0] pend_r[$], pend_g[$], pend_b[$];
  logic [7:0] px_r[NP], px_g[NP], px_b[NP];
  int         gap_before[NP];
  int         n_cmp = 0;
  int         n_err = 0;
  int         pulses;

  pe_pixel_loader #(.NUM_PIXELS(NP), .TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval), .Ack(Ack),
    .Qsd(Qsd), .Qbgd(Qbgd),
    .frame_done(frame_done), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: pixels collect in arrival order; a full batch packs pixel k into byte k.
  task automatic model_accept(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus_t e;
    pend_r.push_back(r);
    pend_g.push_back(g);
    pend_b.push_back(b);
    if (pend_r.size() == NP) begin
      e = '0;
      for (int k = 0; k < NP; k++) begin
        e.r = e.r | (W'(pend_r[k]) << (8 * k));
        e.g = e.g | (W'(pend_g[k]) << (8 * k));
        e.b = e.b | (W'(pend_b[k]) << (8 * k));
      end
      last_batch = e;
      exp_sum.push_back(e);
      pend_r.delete();
      pend_g.delete();
      pend_b.delete();
    end
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge with Reset_n released.
  task automatic apply_reset();
    Reset_n   = 1'b0;
    pix_valid = 1'b0;
    Qsd       = 1'b0;
    Qbgd      = 1'b0;
    pend_r.delete();
    pend_g.delete();
    pend_b.delete();
    @(negedge Clk);
    chk("rst_pix_ready", pix_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_red", red_in, '0);
    chk("rst_green", green_in, '0);
    chk("rst_blue", blue_in, '0);
    chk("rst_pulses", {Start_Sum, Start_BgRemoval, Ack, frame_done}, 4'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    chk("ready_after_reset", pix_ready, 1'b1);
    chk("busy_after_reset", busy, 1'b0);
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) begin
      pix_r = 8'($urandom);
      pix_g = 8'($urandom);
      pix_b = 8'($urandom);
      @(posedge Clk); #1;
    end
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bit got = 1'b0;
    pix_valid = 1'b1;
    pix_r = r;
    pix_g = g;
    pix_b = b;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clk);
      if (pix_ready) got = 1'b1;
      @(posedge Clk); #1;
    end
    if (got) model_accept(r, g, b);
    else chk("pix_ready_wait", 1'b0, 1'b1);
  endtask

  // Plays the pe for one pass; entered after the negedge of the Start cycle (cycle 0).
  // The flag rises at the start of wait cycle d (d=0: already high during Start).
  task automatic run_phase(input int d, input bit is_bg, input bit noise);
    int ack_cyc = 0;
    int exp_cyc = (d < 2) ? 2 : d;
    if (d == 0) begin
      if (is_bg) Qbgd = 1'b1;
      else Qsd = 1'b1;
    end
    for (int c = 1; c <= 40 && ack_cyc == 0; c++) begin
      @(posedge Clk); #1;
      if (c == d) begin
        if (is_bg) Qbgd = 1'b1;
        else Qsd = 1'b1;
      end
      pix_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      pix_r = 8'($urandom);
      @(negedge Clk);
      chk("wait_pix_ready", pix_ready, 1'b0);
      chk("wait_busy", busy, 1'b1);
      if (Ack) ack_cyc = c;
    end
    chk(is_bg ? "ack_cycle_bg" : "ack_cycle_sum", ack_cyc, exp_cyc);
  endtask

  task automatic do_batch(input int d1, input int d2, input bit tmo, input bit noise);
    int acks = 0;
    int fds = 0;
    for (int k = 0; k < NP; k++) begin
      if (gap_before[k] > 0) idle(gap_before[k]);
      send_pixel(px_r[k], px_g[k], px_b[k]);
    end
    pix_valid = 1'b0;
    if (!tmo) exp_done.push_back(last_batch);
    @(negedge Clk);
    chk("start_sum_latency", Start_Sum, 1'b1);
    if (tmo) begin
      Qbgd = 1'b1;
      for (int c = 1; c <= TMO + 1; c++) begin
        @(posedge Clk); #1;
        @(negedge Clk);
        acks += int'(Ack);
        fds  += int'(frame_done);
        if (c <= TMO - 1) chk("tmo_not_yet", timeout_err, 1'b0);
        if (c <= TMO) chk("tmo_busy", busy, 1'b1);
      end
      chk("tmo_err_set", timeout_err, 1'b1);
      chk("tmo_back_to_load_busy", busy, 1'b0);
      chk("tmo_back_to_load_ready", pix_ready, 1'b1);
      chk("tmo_no_ack", acks, 0);
      chk("tmo_no_frame_done", fds, 0);
      Qbgd = 1'b0;
      @(posedge Clk); #1;
    end else begin
      run_phase(d1, 1'b0, noise);
      @(posedge Clk); #1;
      Qsd = 1'b0;
      pix_valid = 1'b0;
      @(negedge Clk);
      chk("start_bg_after_ack", Start_BgRemoval, 1'b1);
      chk("ack_single_sum", Ack, 1'b0);
      run_phase(d2, 1'b1, noise);
      @(posedge Clk); #1;
      Qbgd = 1'b0;
      pix_valid = 1'b0;
      @(negedge Clk);
      chk("frame_done_after_ack", frame_done, 1'b1);
      chk("ack_single_bg", Ack, 1'b0);
      @(posedge Clk); #1;
      chk("idle_busy", busy, 1'b0);
      chk("idle_ready", pix_ready, 1'b1);
      chk("frame_done_pulse_width", frame_done, 1'b0);
    end
  endtask

  task automatic random_pixels();
    for (int k = 0; k < NP; k++) begin
      px_r[k] = 8'($urandom);
      px_g[k] = 8'($urandom);
      px_b[k] = 8'($urandom);
      gap_before[k] = $urandom_range(0, 2);
    end
  endtask

  // Monitor: compare buses against the scoreboard whenever the DUT signals a pass start or a finished batch.
  always @(negedge Clk) begin
    if (Reset_n) begin
      pulses = int'(Start_Sum) + int'(Start_BgRemoval) + int'(Ack) + int'(frame_done);
      if (pulses > 1) chk("pulse_overlap", pulses, 1);
      if (Start_Sum) begin
        if (exp_sum.size() == 0) begin
          chk("unexpected_start_sum", 1'b1, 1'b0);
        end else begin
          mon_e = exp_sum.pop_front();
          chk("sum_red_in", red_in, mon_e.r);
          chk("sum_green_in", green_in, mon_e.g);
          chk("sum_blue_in", blue_in, mon_e.b);
        end
      end
      if (frame_done) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_frame_done", 1'b1, 1'b0);
        end else begin
          mon_e = exp_done.pop_front();
          chk("done_red_in", red_in, mon_e.r);
          chk("done_green_in", green_in, mon_e.g);
          chk("done_blue_in", blue_in, mon_e.b);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    apply_reset();

    // Fixed batch, valid held high, pe done after 7 and 5 cycles.
    px_r = '{8'd204, 8'd61, 8'd61, 8'd61};
    px_g = '{8'd0, 8'd133, 8'd133, 8'd133};
    px_b = '{8'd0, 8'd198, 8'd198, 8'd198};
    gap_before = '{0, 0, 0, 0};
    do_batch(7, 5, 1'b0, 1'b0);
    chk("fixed_red_in", red_in, 32'h3D3D_3DCC);
    chk("fixed_green_in", green_in, 32'h8585_8500);
    chk("fixed_blue_in", blue_in, 32'hC6C6_C600);

    // Gapped valid pattern 1,0,0,1,1,0,1 with pixel noise during the waits.
    random_pixels();
    gap_before = '{0, 2, 0, 1};
    do_batch(3, 4, 1'b0, 1'b1);

    // Done flag already high when the wait state is entered.
    random_pixels();
    do_batch(0, 0, 1'b0, 1'b0);

    // Reset after two of four transfers discards the partial batch.
    random_pixels();
    gap_before = '{0, 0, 0, 0};
    send_pixel(px_r[0], px_g[0], px_b[0]);
    send_pixel(px_r[1], px_g[1], px_b[1]);
    apply_reset();
    random_pixels();
    do_batch(2, 1, 1'b0, 1'b0);

    // pe never signals Qsd: watchdog fires, then a good batch leaves the error sticky.
    random_pixels();
    do_batch(0, 0, 1'b1, 1'b0);
    random_pixels();
    do_batch(5, 6, 1'b0, 1'b1);
    chk("tmo_err_sticky", timeout_err, 1'b1);

    for (int i = 0; i < 20; i++) begin
      random_pixels();
      do_batch($urandom_range(0, 12), $urandom_range(0, 12), 1'b0, 1'($urandom_range(0, 1)));
    end
    chk("tmo_err_still_sticky", timeout_err, 1'b1);

    @(posedge Clk); #1;
    apply_reset();
    chk("sum_queue_drained", exp_sum.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
